// File: rtl/ay_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : ay_bus_responder
// Purpose  : PSG-side responder for the Mockingboard sound-chip bus. Decodes
//            BDIR/BC1/RESET and the data byte coming out of a 6522 port pair,
//            holds an AY-3-8910 compatible 16-entry register file, and returns
//            read data to the VIA's port A input.
// Ports    : clock, reset_n        - system clock, async active-low reset
//            port_a_o / port_a_t   - VIA port A data / direction (1 = driven)
//            port_a_i              - read data back to VIA port A
//            port_b_o / port_b_t   - VIA PB2..0 (RESET_n, BDIR, BC1) / dir
//            tone_period_a/b/c     - 12-bit tone periods
//            noise_period, mixer   - R6[4:0], R7
//            amp_a/b/c             - R8..R10 [4:0]
//            env_period, env_shape - {R12,R11}, R13[3:0]
//            env_restart           - one-cycle pulse per accepted R13 write
// Revision : 1.0 - initial release
// ============================================================================
module ay_bus_responder #(
  parameter logic [3:0] CHIP_SEL = 4'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  port_a_o,
  input  logic [7:0]  port_a_t,
  output logic [7:0]  port_a_i,
  input  logic [2:0]  port_b_o,
  input  logic [2:0]  port_b_t,
  output logic [11:0] tone_period_a,
  output logic [11:0] tone_period_b,
  output logic [11:0] tone_period_c,
  output logic [4:0]  noise_period,
  output logic [7:0]  mixer,
  output logic [4:0]  amp_a,
  output logic [4:0]  amp_b,
  output logic [4:0]  amp_c,
  output logic [15:0] env_period,
  output logic [3:0]  env_shape,
  output logic        env_restart
);

  typedef enum logic [1:0] {
    MODE_INACTIVE = 2'b00,
    MODE_READ     = 2'b01,
    MODE_WRITE    = 2'b10,
    MODE_LATCH    = 2'b11
  } bus_mode_t;

  logic [2:0] pb_eff;
  logic [7:0] data_eff;
  logic       chip_run;
  bus_mode_t  mode;
  bus_mode_t  mode_q;
  logic       mode_entered;
  logic       latch_en;
  logic       write_en;
  logic [7:0] wr_mask;
  logic [3:0] addr_q;
  logic       sel_q;
  logic [7:0] regs [16];

  // Undriven VIA pins float high through the board pull-ups.
  assign pb_eff   = port_b_o | ~port_b_t;
  assign data_eff = port_a_o | ~port_a_t;

  assign chip_run     = pb_eff[2];
  assign mode         = bus_mode_t'(pb_eff[1:0]);
  // mode_q keeps tracking during chip reset, so a mode already held when
  // PB2 rises is not seen as a fresh entry.
  assign mode_entered = (mode != mode_q);
  assign latch_en     = chip_run && mode_entered && (mode == MODE_LATCH);
  assign write_en     = chip_run && mode_entered && (mode == MODE_WRITE) && sel_q;

  // Unimplemented bits of the narrow registers are stored as zero so that
  // readback matches the real chip.
  always_comb begin
    wr_mask = 8'hFF;
    case (addr_q)
      4'd1, 4'd3, 4'd5, 4'd13:        wr_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10:        wr_mask = 8'h1F;
      default:                        wr_mask = 8'hFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 8'h00;
      end
      addr_q      <= 4'h0;
      sel_q       <= 1'b0;
      env_restart <= 1'b0;
      mode_q      <= MODE_INACTIVE;
    end else begin
      mode_q      <= mode;
      env_restart <= write_en && (addr_q == 4'd13);
      if (!chip_run) begin
        for (int i = 0; i < 16; i++) begin
          regs[i] <= 8'h00;
        end
        addr_q <= 4'h0;
        sel_q  <= 1'b0;
      end else begin
        if (latch_en) begin
          addr_q <= data_eff[3:0];
          sel_q  <= (data_eff[7:4] == CHIP_SEL);
        end
        if (write_en) begin
          regs[addr_q] <= data_eff & wr_mask;
        end
      end
    end
  end

  // Combinational readback so a READ right after a WRITE sees the new value.
  assign port_a_i = (chip_run && (mode == MODE_READ) && sel_q) ? regs[addr_q] : 8'hFF;

  assign tone_period_a = {regs[1][3:0], regs[0]};
  assign tone_period_b = {regs[3][3:0], regs[2]};
  assign tone_period_c = {regs[5][3:0], regs[4]};
  assign noise_period  = regs[6][4:0];
  assign mixer         = regs[7];
  assign amp_a         = regs[8][4:0];
  assign amp_b         = regs[9][4:0];
  assign amp_c         = regs[10][4:0];
  assign env_period    = {regs[12], regs[11]};
  assign env_shape     = regs[13][3:0];

endmodule
`default_nettype wire
